mdu_issue_ctrl: RTL

- Initiator side of the MDU start/busy handshake.
- Sits between the D and E pipeline stages. It holds the E-stage copy of the MDU opcode and drives `start`/`MDUOp` into the multiply-divide unit.
- Stalls D whenever the D-stage instruction needs HI/LO or the MDU while an operation is pending or running.
- Runs its own latency counter as a shadow of the MDU and flags any mismatch against `busy`.

---
 rtl/mdu_issue_ctrl_pkg.sv | 37 +++
 rtl/mdu_lat_counter.sv | 44 ++++
 rtl/mdu_issue_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU issue definitions: opcode classes, default latencies and
// controller state encoding.
package mdu_issue_ctrl_pkg;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W       = 4;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_MF    = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_class(input logic [2:0] op);
    return op != MDU_NONE;
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// Shadow latency counter for the MDU: counts the expected busy window and
// reports when the observed busy level disagrees with it.
module mdu_lat_counter
  import mdu_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             chk_idle,
  input  logic             mdu_busy,
  output logic [CNT_W-1:0] cnt,
  output logic             done,
  output logic             busy_err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = dec && (cnt_q == CNT_W'(1));

  // Start and completion edges are not checked: busy changes on exactly those edges.
  assign busy_err = (dec && (cnt_q > CNT_W'(1)) && !mdu_busy) ||
                    (chk_idle && mdu_busy);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// D/E-stage issue controller for the multiply-divide unit: E-stage opcode
// register, start generation, D-stage stall and a shadow busy checker.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       D_MDUOp,
  input  logic             D_valid,
  input  logic             E_flush,
  input  logic             mdu_busy,
  output logic             D_stall,
  output logic [2:0]       E_MDUOp,
  output logic             start,
  output logic             hilo_ready,
  output logic             lat_err,
  output state_e           dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  state_e           state_q, state_d;
  logic [2:0]       e_op_q, e_op_d;
  logic             lat_err_q, lat_err_d;
  logic             run, e_arith, hold_e;
  logic             cnt_done, busy_err;
  logic [CNT_W-1:0] cnt_load_val, cnt;

  // Handshake: start is a single-cycle request taken by the MDU on the next
  // posedge; busy rises on that edge and falls on the edge HI/LO is written.
  // There is no back-pressure on start, so it is only raised from IDLE.
  assign run      = (state_q == ST_RUN);
  assign e_arith  = is_arith(e_op_q);
  assign start    = e_arith && !run;
  assign hold_e   = e_arith && run;
  assign D_stall  = D_valid && is_class(D_MDUOp) && (start || run);
  assign hilo_ready = !run && !start;

  assign cnt_load_val = is_div(e_op_q) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  mdu_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (cnt_load_val),
    .dec      (run),
    .chk_idle (hilo_ready),
    .mdu_busy (mdu_busy),
    .cnt      (cnt),
    .done     (cnt_done),
    .busy_err (busy_err)
  );

  always_comb begin
    e_op_d = D_valid ? D_MDUOp : MDU_NONE;
    if (D_stall) begin
      e_op_d = MDU_NONE;
    end
    // An arith op stranded in E behind a running op is kept until it can issue.
    if (hold_e) begin
      e_op_d = e_op_q;
    end
    if (E_flush) begin
      e_op_d = MDU_NONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (cnt_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign lat_err_d = lat_err_q || busy_err || hold_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      e_op_q    <= MDU_NONE;
      lat_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      e_op_q    <= e_op_d;
      lat_err_q <= lat_err_d;
    end
  end

  assign E_MDUOp   = e_op_q;
  assign lat_err   = lat_err_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt;

endmodule
